// File: rtl/core_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// core : shared core types (bool, branch tag, predictor feedback)  | rev 1.0
// ---------------------------------------------------------------------------
package core;

  localparam int pc_width        = 32;
  localparam int branch_fb_depth = 8;

  typedef logic bool;

  typedef logic [$clog2(branch_fb_depth)-1:0] branch_tag_t;

  typedef struct packed {
    logic                valid;
    logic [pc_width-1:0] base_pc;
    logic                branch_taken;
  } branch_pred_fb_t;

endpackage
`default_nettype wire

// File: rtl/branch_fb_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// branch_fb_gen : in-order branch feedback generator with flush on mispredict
// rev 1.0
// ---------------------------------------------------------------------------
module branch_fb_gen
  import core::*;
#(
  parameter int DEPTH    = core::branch_fb_depth,
  parameter int PC_WIDTH = core::pc_width
) (
  input  logic                       clk,
  input  logic                       rst,
  input  bool                        en,
  input  logic                       alloc_valid,
  input  logic [PC_WIDTH-1:0]        alloc_pc,
  input  logic                       alloc_pred_taken,
  input  logic                       alloc_eval_alt,
  output logic                       alloc_ready,
  output logic [$clog2(DEPTH)-1:0]   alloc_tag,
  input  logic                       res_valid,
  input  logic [$clog2(DEPTH)-1:0]   res_tag,
  input  logic                       res_taken,
  output branch_pred_fb_t            fb,
  output logic                       flush,
  output logic [$clog2(DEPTH)-1:0]   flush_tag,
  output logic                       flush_taken,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int          TW   = $clog2(DEPTH);
  localparam logic [TW:0] FULL = (TW+1)'(DEPTH);
  localparam logic [TW:0] ONE  = (TW+1)'(1);

  typedef struct packed {
    logic                valid;
    logic                resolved;
    logic [PC_WIDTH-1:0] pc;
    logic                pred_taken;
    logic                eval_alt;
    logic                actual_taken;
  } fb_entry_t;

  fb_entry_t     entries [DEPTH];
  logic [TW:0]   head;
  logic [TW:0]   tail;
  logic [TW-1:0] head_idx;
  logic [TW-1:0] tail_idx;
  logic [TW-1:0] res_off;
  fb_entry_t     res_ent;
  fb_entry_t     head_ent;
  logic          res_accept;
  logic          squash_now;
  logic          retire;
  logic          alloc_fire;

  assign head_idx    = head[TW-1:0];
  assign tail_idx    = tail[TW-1:0];
  assign count       = tail - head;
  assign res_ent     = entries[res_tag];
  assign head_ent    = entries[head_idx];
  assign res_accept  = en && res_valid && res_ent.valid && !res_ent.resolved;
  assign squash_now  = res_accept && (res_taken != res_ent.pred_taken) && !res_ent.eval_alt;
  assign alloc_ready = (count < FULL) && !squash_now;
  assign alloc_tag   = tail_idx;
  assign retire      = en && head_ent.valid && head_ent.resolved;
  assign alloc_fire  = en && alloc_valid && alloc_ready;
  // Distance of the resolving entry from head; everything further out is younger.
  assign res_off     = res_tag - head_idx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head <= '0;
      tail <= '0;
    end else begin
      if (retire)
        head <= head + ONE;
      if (squash_now)
        tail <= head + {1'b0, res_off} + ONE;
      else if (alloc_fire)
        tail <= tail + ONE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++)
        entries[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (retire && head_idx == TW'(i))
          entries[i].valid <= 1'b0;
        if (res_accept && res_tag == TW'(i)) begin
          entries[i].resolved     <= 1'b1;
          entries[i].actual_taken <= res_taken;
        end
        if (squash_now && (TW'(i) - head_idx) > res_off)
          entries[i].valid <= 1'b0;
        // Squash blocks allocation, so this never collides with the kill above.
        if (alloc_fire && tail_idx == TW'(i)) begin
          entries[i].valid        <= 1'b1;
          entries[i].resolved     <= 1'b0;
          entries[i].pc           <= alloc_pc;
          entries[i].pred_taken   <= alloc_pred_taken;
          entries[i].eval_alt     <= alloc_eval_alt;
          entries[i].actual_taken <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fb          <= '0;
      flush       <= 1'b0;
      flush_tag   <= '0;
      flush_taken <= 1'b0;
    end else begin
      fb.valid <= retire;
      if (retire) begin
        fb.base_pc      <= head_ent.pc;
        fb.branch_taken <= head_ent.actual_taken;
      end
      flush <= squash_now;
      if (squash_now) begin
        flush_tag   <= res_tag;
        flush_taken <= res_taken;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_branch_fb_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_branch_fb_gen : scoreboard bench with an in-flight list reference model
// rev 1.0
// ---------------------------------------------------------------------------
module tb_branch_fb_gen;
  import core::*;

  localparam int D  = 8;
  localparam int TW = 3;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            en = 1'b0;
  logic            alloc_valid = 1'b0;
  logic [31:0]     alloc_pc = '0;
  logic            alloc_pred_taken = 1'b0;
  logic            alloc_eval_alt = 1'b0;
  logic            alloc_ready;
  logic [TW-1:0]   alloc_tag;
  logic            res_valid = 1'b0;
  logic [TW-1:0]   res_tag = '0;
  logic            res_taken = 1'b0;
  branch_pred_fb_t fb;
  logic            flush;
  logic [TW-1:0]   flush_tag;
  logic            flush_taken;
  logic [TW:0]     count;

  branch_fb_gen #(.DEPTH(D), .PC_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .en(en),
    .alloc_valid(alloc_valid), .alloc_pc(alloc_pc),
    .alloc_pred_taken(alloc_pred_taken), .alloc_eval_alt(alloc_eval_alt),
    .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .res_valid(res_valid), .res_tag(res_tag), .res_taken(res_taken),
    .fb(fb), .flush(flush), .flush_tag(flush_tag), .flush_taken(flush_taken),
    .count(count)
  );

  always #5 clk = ~clk;

  typedef struct { int tag; logic [31:0] pc; bit pred; bit alt; bit res; bit act; } br_t;
  typedef struct { logic [31:0] pc; bit taken; } fbx_t;
  typedef struct { int tag; bit taken; } flx_t;

  br_t  model [$];   // in-flight branches, oldest first
  fbx_t fb_q  [$];
  flx_t fl_q  [$];
  int   next_tag;
  int   checks;
  int   errors;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus; the model applies the same cycle's rules in list form.
  task automatic cycle(input bit e, input bit av, input logic [31:0] pc, input bit pt,
                       input bit alt, input bit rv, input int rt, input bit rtk);
    int idx;
    bit squash, ready, retire;
    @(negedge clk);
    en = e; alloc_valid = av; alloc_pc = pc; alloc_pred_taken = pt; alloc_eval_alt = alt;
    res_valid = rv; res_tag = TW'(rt); res_taken = rtk;
    idx = -1;
    squash = 0;
    if (e && rv)
      foreach (model[i])
        if (model[i].tag == rt && !model[i].res) idx = i;
    if (idx >= 0 && model[idx].pred != rtk && !model[idx].alt) squash = 1;
    ready  = (model.size() < D) && !squash;
    retire = e && model.size() > 0 && model[0].res;
    #1;
    check("alloc_ready", alloc_ready, ready);
    check("alloc_tag", alloc_tag, next_tag);
    check("count", count, model.size());
    if (idx >= 0) begin
      model[idx].res = 1;
      model[idx].act = rtk;
      if (squash) begin
        while (model.size() > idx + 1) void'(model.pop_back());
        next_tag = (rt + 1) % D;
        fl_q.push_back('{rt, rtk});
      end
    end
    if (retire) begin
      fb_q.push_back('{model[0].pc, model[0].act});
      void'(model.pop_front());
    end
    if (e && av && ready) begin
      model.push_back('{next_tag, pc, pt, alt, 1'b0, 1'b0});
      next_tag = (next_tag + 1) % D;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic clear_model();
    model.delete(); fb_q.delete(); fl_q.delete(); next_tag = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #3 rst = 1'b0; en = 0; alloc_valid = 0; res_valid = 0;
    #1;
    check("rst_fb_valid", fb.valid, 0);
    check("rst_flush", flush, 0);
    check("rst_flush_tag", flush_tag, 0);
    check("rst_count", count, 0);
    clear_model();
    @(negedge clk);
    #3 rst = 1'b1;
  endtask

  // Monitor: every output pulse must match the oldest pending expectation.
  always @(negedge clk) begin : monitor
    fbx_t x;
    flx_t y;
    if (rst) begin
      if (fb.valid || fb_q.size() > 0) begin
        if (fb_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL fb_unexpected: got valid pc %0h, expected none", fb.base_pc);
        end else begin
          x = fb_q.pop_front();
          check("fb_valid", fb.valid, 1);
          check("fb_pc", fb.base_pc, x.pc);
          check("fb_taken", fb.branch_taken, x.taken);
        end
      end
      if (flush || fl_q.size() > 0) begin
        if (fl_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL flush_unexpected: got tag %0d, expected none", flush_tag);
        end else begin
          y = fl_q.pop_front();
          check("flush", flush, 1);
          check("flush_tag", flush_tag, y.tag);
          check("flush_taken", flush_taken, y.taken);
        end
      end
    end
  end

  bit          e, av, pt, alt, rv, rtk;
  int          rt, k;
  logic [31:0] rpc;

  initial begin
    checks = 0; errors = 0; next_tag = 0;
    do_reset();

    // Single branch round trip
    cycle(1, 1, 32'h100, 1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 1, 0, 1);
    idle(3);

    // Out-of-order resolution, in-order feedback
    do_reset();
    cycle(1, 1, 32'h10, 1, 0, 0, 0, 0);
    cycle(1, 1, 32'h20, 1, 0, 0, 0, 0);
    cycle(1, 1, 32'h30, 1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 1, 2, 1);
    cycle(1, 0, 0, 0, 0, 1, 1, 1);
    cycle(1, 0, 0, 0, 0, 1, 0, 1);
    idle(5);

    // Mispredict on tag 1 squashes 2 and 3; stale resolve of 2 ignored
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1, 1, 32'h200 + 32'(i * 4), 0, 0, 0, 0, 0);
    cycle(1, 1, 32'h2f0, 0, 0, 1, 1, 1);
    cycle(1, 0, 0, 0, 0, 1, 2, 0);
    cycle(1, 1, 32'h240, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 1, 0, 0);
    cycle(1, 0, 0, 0, 0, 1, 2, 0);
    idle(5);

    // Same shape but tag 1 evaluates both paths: no flush
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1, 1, 32'h300 + 32'(i * 4), 0, (i == 1), 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 1, 1, 1);
    cycle(1, 0, 0, 0, 0, 1, 0, 0);
    cycle(1, 0, 0, 0, 0, 1, 2, 0);
    cycle(1, 0, 0, 0, 0, 1, 3, 0);
    idle(6);

    // Full buffer, dropped allocation, retire from full, tail wrap
    do_reset();
    for (int i = 0; i < 9; i++) cycle(1, 1, 32'h400 + 32'(i * 4), 1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 1, 0, 1);
    idle(3);
    for (int i = 1; i < 20; i++) cycle(1, 1, 32'h500 + 32'(i * 4), 1, 0, 1, i % D, 1);
    idle(12);

    // Randomized traffic
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      e   = ($urandom_range(0, 9) != 0);
      av  = ($urandom_range(0, 2) != 0);
      pt  = $urandom_range(0, 1);
      alt = ($urandom_range(0, 3) == 0);
      rv  = $urandom_range(0, 1);
      rpc = $urandom;
      if (model.size() > 0 && $urandom_range(0, 3) != 0) begin
        k   = $urandom_range(0, model.size() - 1);
        rt  = model[k].tag;
        rtk = ($urandom_range(0, 7) == 0) ? !model[k].pred : model[k].pred;
      end else begin
        rt  = $urandom_range(0, D - 1);
        rtk = $urandom_range(0, 1);
      end
      cycle(e, av, rpc, pt, alt, rv, rt, rtk);
    end
    for (int n = 0; n < 40; n++) begin
      if (model.size() > 0) cycle(1, 0, 0, 0, 0, 1, model[model.size() - 1].tag, model[model.size() - 1].pred);
      else cycle(1, 0, 0, 0, 0, 0, 0, 0);
    end
    idle(3);

    // Asynchronous reset mid-operation: 5 in flight, head resolved, fb pulsing
    do_reset();
    for (int i = 0; i < 6; i++) cycle(1, 1, 32'h600 + 32'(i * 4), 1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 1, 0, 1);
    cycle(1, 0, 0, 0, 0, 1, 1, 1);
    @(posedge clk);
    #3;
    check("pre_rst_fb_valid", fb.valid, 1);
    check("pre_rst_count", count, 5);
    rst = 1'b0;
    #1;
    check("async_fb_valid", fb.valid, 0);
    check("async_flush", flush, 0);
    check("async_count", count, 0);
    clear_model();
    @(negedge clk);
    #3 rst = 1'b1;
    #1 check("post_rst_alloc_tag", alloc_tag, 0);
    cycle(1, 1, 32'h700, 1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 1, 0, 1);
    idle(3);

    check("fb_pending", fb_q.size(), 0);
    check("flush_pending", fl_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
